// File: rtl/hand_clk_gen.sv
// hand_clk_gen: manual single-step CPU clock. The raw pushbutton is
// synchronized, debounced on tick_en, and each accepted press (plus
// optional auto-repeat while held) yields one fixed-width hand_clk pulse.
module hand_clk_gen #(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned HOLD_CNT     = 64,
  parameter int unsigned REPEAT_CNT   = 16,
  parameter int unsigned HIGH_TICKS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        btn_raw,
  input  logic        repeat_en,
  output logic        hand_clk,
  output logic        step_pulse,
  output logic        btn_stable,
  output logic [15:0] step_count
);

  localparam int unsigned DB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int unsigned T_MAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
  localparam int unsigned T_W   = $clog2(T_MAX + 1);
  localparam int unsigned H_W   = (HIGH_TICKS > 1) ? $clog2(HIGH_TICKS) : 1;

  generate
    if (REPEAT_CNT <= HIGH_TICKS) begin : g_bad_repeat
      $error("hand_clk_gen: REPEAT_CNT must be greater than HIGH_TICKS");
    end
    if (DEBOUNCE_CNT == 0 || HOLD_CNT == 0 || HIGH_TICKS == 0) begin : g_bad_zero
      $error("hand_clk_gen: DEBOUNCE_CNT, HOLD_CNT and HIGH_TICKS must be non-zero");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  // Synchronizer
  logic sync1_q, sync2_q;
  logic btn_sync;

  // Debouncer
  logic            btn_stable_q, btn_stable_d;
  logic            btn_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_rise;

  // Step FSM
  state_e         state_q, state_d;
  logic [T_W-1:0] t_cnt_q, t_cnt_d;
  logic [T_W-1:0] t_inc, t_hold_nx;
  logic           hold_expire, repeat_expire;
  logic           step_req;

  // Pulse generator
  logic            hand_clk_q, hand_clk_d;
  logic            step_pulse_q, step_pulse_d;
  logic [H_W-1:0]  h_cnt_q, h_cnt_d;
  logic [15:0]     step_count_q, step_count_d;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign btn_sync = sync2_q;

  // Debounce: accept a new level after DEBOUNCE_CNT consecutive mismatching ticks
  always_comb begin
    db_cnt_d     = db_cnt_q;
    btn_stable_d = btn_stable_q;
    if (btn_sync == btn_stable_q) begin
      db_cnt_d = '0;
    end else if (tick_en) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
        btn_stable_d = btn_sync;
        db_cnt_d     = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_stable_q <= 1'b0;
      btn_prev_q   <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      btn_stable_q <= btn_stable_d;
      btn_prev_q   <= btn_stable_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign btn_rise = btn_stable_q & ~btn_prev_q;

  // Release is judged on the debouncer's next value, so a release accepted
  // on the same tick as a hold/repeat expiry suppresses that step.
  assign t_inc         = t_cnt_q + T_W'(1);
  assign t_hold_nx     = (t_cnt_q == T_W'(HOLD_CNT)) ? t_cnt_q : t_inc;
  assign hold_expire   = btn_stable_d & repeat_en & tick_en & (t_hold_nx == T_W'(HOLD_CNT));
  assign repeat_expire = btn_stable_d & repeat_en & tick_en & (t_inc == T_W'(REPEAT_CNT));

  // FSM state register and tick counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      t_cnt_q <= t_cnt_d;
    end
  end

  // FSM next-state and tick counter update
  always_comb begin
    state_d = state_q;
    t_cnt_d = t_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_rise) begin
          state_d = ST_HOLD;
          t_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (!btn_stable_d) begin
          state_d = ST_IDLE;
          t_cnt_d = '0;
        end else if (hold_expire) begin
          state_d = ST_REPEAT;
          t_cnt_d = '0;
        end else if (tick_en) begin
          t_cnt_d = t_hold_nx;
        end
      end
      ST_REPEAT: begin
        if (!btn_stable_d || !repeat_en) begin
          state_d = ST_IDLE;
          t_cnt_d = '0;
        end else if (repeat_expire) begin
          t_cnt_d = '0;
        end else if (tick_en) begin
          t_cnt_d = t_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_cnt_d = '0;
      end
    endcase
  end

  // FSM output: one-clk step request
  always_comb begin
    step_req = 1'b0;
    case (state_q)
      ST_IDLE:   step_req = btn_rise;
      ST_HOLD:   step_req = hold_expire;
      ST_REPEAT: step_req = repeat_expire;
      default:   step_req = 1'b0;
    endcase
  end

  // Pulse generator: a request while hand_clk is high is dropped
  always_comb begin
    hand_clk_d   = hand_clk_q;
    h_cnt_d      = h_cnt_q;
    step_pulse_d = 1'b0;
    step_count_d = step_count_q;
    if (hand_clk_q) begin
      if (tick_en) begin
        if (h_cnt_q == H_W'(HIGH_TICKS - 1)) begin
          hand_clk_d = 1'b0;
          h_cnt_d    = '0;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
    end else if (step_req) begin
      hand_clk_d   = 1'b1;
      h_cnt_d      = '0;
      step_pulse_d = 1'b1;
      step_count_d = step_count_q + 16'd1;
    end
  end

  // Pulse generator registers and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hand_clk_q   <= 1'b0;
      h_cnt_q      <= '0;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      hand_clk_q   <= hand_clk_d;
      h_cnt_q      <= h_cnt_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign hand_clk   = hand_clk_q;
  assign step_pulse = step_pulse_q;
  assign btn_stable = btn_stable_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_hand_clk_gen.sv
// Testbench for hand_clk_gen: directed button scenarios; each expected step
// (cycle, count, high width) is queued and checked by an independent monitor.
module tb_hand_clk_gen;

  logic        clk;
  logic        rst;
  logic        tick_en;
  logic        btn_raw;
  logic        repeat_en;
  logic        hand_clk;
  logic        step_pulse;
  logic        btn_stable;
  logic [15:0] step_count;

  int cyc    = 0;
  int total  = 0;
  int passed = 0;
  bit fast_tick = 1'b0;

  typedef struct {
    int cyc;
    int cnt;
    int width;
  } exp_t;

  exp_t sb[$];

  hand_clk_gen #(
    .DEBOUNCE_CNT(4),
    .HOLD_CNT    (8),
    .REPEAT_CNT  (4),
    .HIGH_TICKS  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_en   (tick_en),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .hand_clk  (hand_clk),
    .step_pulse(step_pulse),
    .btn_stable(btn_stable),
    .step_count(step_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // tick_en sampled high at every rising edge whose index is a multiple of 4,
  // or at every edge in fast mode
  initial begin
    tick_en = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      tick_en = fast_tick ? 1'b1 : (cyc % 4 == 3);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_step(input int at, input int cnt, input int width);
    exp_t e;
    e.cyc   = at;
    e.cnt   = cnt;
    e.width = width;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic align(output int c);
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    c = cyc;
  endtask

  // Monitor: every step_pulse must match the head of the scoreboard
  initial begin
    int   w;
    exp_t e;
    forever begin
      @(negedge clk);
      if (step_pulse === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_step: step_pulse at cycle %0d count %0d, none expected",
                   cyc, step_count);
        end else begin
          e = sb.pop_front();
          check("step_cycle", cyc, e.cyc);
          check("step_count", int'(step_count), e.cnt);
          w = 0;
          while (hand_clk === 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
          end
          check("high_width", w, e.width);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst       = 1'b1;
    btn_raw   = 1'b0;
    repeat_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hand_clk",   int'(hand_clk),   0);
    check("rst_step_pulse", int'(step_pulse), 0);
    check("rst_btn_stable", int'(btn_stable), 0);
    check("rst_step_count", int'(step_count), 0);
    rst = 1'b0;

    // Clean press, no repeat
    align(c);
    btn_raw = 1'b1;
    expect_step(c + 17, 1, 7);
    wait_until(c + 15);
    check("clean_stable_early", int'(btn_stable), 0);
    wait_until(c + 16);
    check("clean_stable_rise", int'(btn_stable), 1);
    wait_until(c + 40);
    btn_raw = 1'b0;
    wait_until(c + 60);
    check("clean_released", int'(btn_stable), 0);
    check("clean_count", int'(step_count), 1);

    // Reset while hand_clk is high, button kept pressed
    align(c);
    btn_raw = 1'b1;
    expect_step(c + 17, 2, 3);
    wait_until(c + 19);
    #1 rst = 1'b1;
    #1;
    check("midrst_hand_clk",   int'(hand_clk),   0);
    check("midrst_step_pulse", int'(step_pulse), 0);
    check("midrst_btn_stable", int'(btn_stable), 0);
    check("midrst_step_count", int'(step_count), 0);
    @(negedge clk);
    wait_until(c + 21);
    rst = 1'b0;
    expect_step(c + 37, 1, 7);
    wait_until(c + 35);
    check("postrst_stable_early", int'(btn_stable), 0);
    wait_until(c + 36);
    check("postrst_stable_rise", int'(btn_stable), 1);
    wait_until(c + 44);
    btn_raw = 1'b0;
    wait_until(c + 64);

    // Bounce: five one-tick high/low cycles, then a steady press
    align(c);
    for (int k = 0; k < 5; k++) begin
      btn_raw = 1'b1;
      wait_until(c + 8 * k + 4);
      btn_raw = 1'b0;
      wait_until(c + 8 * k + 8);
    end
    check("bounce_no_stable", int'(btn_stable), 0);
    btn_raw = 1'b1;
    expect_step(c + 57, 2, 7);
    wait_until(c + 80);
    btn_raw = 1'b0;
    wait_until(c + 100);

    // Auto-repeat: first step, hold expiry, then two repeat steps;
    // release lands inside the last high phase
    align(c);
    repeat_en = 1'b1;
    btn_raw   = 1'b1;
    expect_step(c + 17, 3, 7);
    expect_step(c + 48, 4, 8);
    expect_step(c + 64, 5, 8);
    expect_step(c + 80, 6, 8);
    wait_until(c + 68);
    btn_raw = 1'b0;
    wait_until(c + 83);
    check("repeat_stable_held", int'(btn_stable), 1);
    wait_until(c + 84);
    check("repeat_stable_fall", int'(btn_stable), 0);
    wait_until(c + 110);
    repeat_en = 1'b0;

    // Repeat disabled for 100 ticks, then enabled, then lowered in REPEAT
    align(c);
    btn_raw = 1'b1;
    expect_step(c + 17, 7, 7);
    wait_until(c + 417);
    repeat_en = 1'b1;
    expect_step(c + 420, 8, 8);
    wait_until(c + 434);
    repeat_en = 1'b0;
    wait_until(c + 480);
    check("norepeat_count", int'(step_count), 8);
    btn_raw = 1'b0;
    wait_until(c + 520);

    // Wrap with tick_en held high; counter jumped close to the wrap point.
    // Release is accepted on the same tick as the next repeat expiry.
    @(negedge clk);
    force dut.step_count_q = 16'hFFFC;
    repeat (2) @(negedge clk);
    release dut.step_count_q;
    fast_tick = 1'b1;
    @(negedge clk);
    c = cyc;
    btn_raw   = 1'b1;
    repeat_en = 1'b1;
    expect_step(c + 7,  16'hFFFD, 2);
    expect_step(c + 15, 16'hFFFE, 2);
    expect_step(c + 19, 16'hFFFF, 2);
    expect_step(c + 23, 16'h0000, 2);
    expect_step(c + 27, 16'h0001, 2);
    wait_until(c + 25);
    btn_raw = 1'b0;
    wait_until(c + 30);
    check("race_stable_before", int'(btn_stable), 1);
    wait_until(c + 31);
    check("race_stable_fall", int'(btn_stable), 0);
    wait_until(c + 60);
    check("wrap_final_count", int'(step_count), 1);
    repeat_en = 1'b0;

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
